// File: rtl/dma_channel_regfile.sv
// -----------------------------------------------------------------------------
// dma_channel_regfile
// CPU-programmable DMA register file: command register plus, per channel,
// mode, mask, software request, terminal-count status and base/current
// address and count. The CPU reaches it over an 8-bit strobe bus. The transfer
// engine reports each completed transfer on step and each external
// end-of-process on ext_eop.
//
// Ports
//   clk            clock, all state on rising edge
//   RESET_n        asynchronous reset, active low
//   CS_n/IOR_n/IOW_n  chip select / read / write strobes, active low
//   A              register address
//   DB_in          write data
//   DB_out         registered read data, loaded on a read access
//   DB_oe          read-drive enable (combinational)
//   step           per-channel transfer-complete pulse
//   ext_eop        per-channel external end-of-process pulse
//   command        command register
//   mode_flat      mode[7:2] of channel i at [6i+5:6i]
//   mask           channel mask bits
//   sw_req         software request bits
//   cur_addr_flat  current address of channel i at [AW*i+AW-1:AW*i]
//   tc             one-cycle terminal-count pulse per channel
// -----------------------------------------------------------------------------
module dma_channel_regfile #(
    parameter int         NUM_CH  = 4,
    parameter int         AW      = 16,
    parameter logic [7:0] CMD_RST = 8'h00
) (
    input  logic                 clk,
    input  logic                 RESET_n,
    input  logic                 CS_n,
    input  logic                 IOR_n,
    input  logic                 IOW_n,
    input  logic [3:0]           A,
    input  logic [7:0]           DB_in,
    output logic [7:0]           DB_out,
    output logic                 DB_oe,
    input  logic [NUM_CH-1:0]    step,
    input  logic [NUM_CH-1:0]    ext_eop,
    output logic [7:0]           command,
    output logic [6*NUM_CH-1:0]  mode_flat,
    output logic [NUM_CH-1:0]    mask,
    output logic [NUM_CH-1:0]    sw_req,
    output logic [AW*NUM_CH-1:0] cur_addr_flat,
    output logic [NUM_CH-1:0]    tc
);

    // The byte pointer only has meaning when a register spans two bytes.
    localparam logic PTR_EN = (AW == 16);

    logic rd_cond, wr_cond, rd_cond_q, wr_cond_q;
    logic rd_ev, wr_ev, mclr, stat_rd, ptr;
    logic [NUM_CH-1:0] tc_flag;
    logic [3:0][15:0]  addr_ext, cnt_ext;
    logic [7:0]        rd_data, status;
    logic [15:0]       sel16;

    // An access is one cycle of CS_n low with exactly one strobe low; only the
    // first such cycle acts, so a held strobe is a single event.
    assign rd_cond = !CS_n && !IOR_n && IOW_n;
    assign wr_cond = !CS_n && !IOW_n && IOR_n;
    assign rd_ev   = rd_cond && !rd_cond_q;
    assign wr_ev   = wr_cond && !wr_cond_q;
    assign DB_oe   = rd_cond;
    assign mclr    = wr_ev && (A == 4'd13);
    assign stat_rd = rd_ev && (A == 4'd8);
    assign status  = {4'(sw_req), 4'(tc_flag)};

    function automatic logic [15:0] put_byte(input logic [15:0] v, input logic hi,
                                             input logic [7:0] d);
        put_byte = hi ? {d, v[7:0]} : {v[15:8], d};
    endfunction

    always_comb begin
        rd_data = 8'h00;
        sel16   = A[0] ? cnt_ext[A[2:1]] : addr_ext[A[2:1]];
        if (!A[3])
            rd_data = ptr ? sel16[15:8] : sel16[7:0];
        else if (A == 4'd8)
            rd_data = status;
    end

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            rd_cond_q <= 1'b0;
            wr_cond_q <= 1'b0;
            command   <= CMD_RST;
            ptr       <= 1'b0;
            DB_out    <= 8'h00;
        end else begin
            rd_cond_q <= rd_cond;
            wr_cond_q <= wr_cond;
            if (mclr) begin
                command <= CMD_RST;
                ptr     <= 1'b0;
                DB_out  <= 8'h00;
            end else begin
                if (wr_ev && A == 4'd8)
                    command <= DB_in;
                if (wr_ev && A == 4'd12)
                    ptr <= 1'b0;
                else if ((rd_ev || wr_ev) && !A[3])
                    ptr <= PTR_EN & ~ptr;
                if (rd_ev)
                    DB_out <= rd_data;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [AW-1:0] base_addr, cur_addr, base_cnt, cur_cnt;
        logic [5:0]    mode_r;
        logic          mask_r, req_r, flag_r, tc_r;
        logic          wr_addr, wr_cnt, ch_arg, blocked, do_step, do_eop, tc_now;
        logic          auto_init, dec;

        assign wr_addr   = wr_ev && (A == 4'(2*i));
        assign wr_cnt    = wr_ev && (A == 4'(2*i+1));
        assign ch_arg    = wr_ev && (DB_in[1:0] == 2'(i));
        assign auto_init = mode_r[2];
        assign dec       = mode_r[3];
        // A CPU write to this channel's address/count owns the cycle; the
        // engine's step/EOP for this channel is discarded.
        assign blocked   = command[2] || wr_addr || wr_cnt;
        assign do_step   = step[i] && !blocked;
        assign do_eop    = ext_eop[i] && !blocked;
        assign tc_now    = (do_step && cur_cnt == '0) || do_eop;

        always_ff @(posedge clk or negedge RESET_n) begin
            if (!RESET_n) begin
                base_addr <= '0; cur_addr <= '0; base_cnt <= '0; cur_cnt <= '0;
                mode_r <= '0; mask_r <= 1'b1; req_r <= 1'b0; flag_r <= 1'b0; tc_r <= 1'b0;
            end else if (mclr) begin
                base_addr <= '0; cur_addr <= '0; base_cnt <= '0; cur_cnt <= '0;
                mode_r <= '0; mask_r <= 1'b1; req_r <= 1'b0; flag_r <= 1'b0; tc_r <= 1'b0;
            end else begin
                if (wr_addr) begin
                    base_addr <= AW'(put_byte(16'(base_addr), ptr, DB_in));
                    cur_addr  <= AW'(put_byte(16'(cur_addr), ptr, DB_in));
                end else if (tc_now && auto_init)
                    cur_addr <= base_addr;
                else if (do_step)
                    cur_addr <= dec ? cur_addr - AW'(1) : cur_addr + AW'(1);

                // Count decrements unconditionally, so a step at zero wraps to
                // all-ones while signalling TC.
                if (wr_cnt) begin
                    base_cnt <= AW'(put_byte(16'(base_cnt), ptr, DB_in));
                    cur_cnt  <= AW'(put_byte(16'(cur_cnt), ptr, DB_in));
                end else if (tc_now && auto_init)
                    cur_cnt <= base_cnt;
                else if (do_step)
                    cur_cnt <= cur_cnt - AW'(1);

                if (ch_arg && A == 4'd11)
                    mode_r <= DB_in[7:2];

                // TC mask-set outranks any CPU mask write in the same cycle.
                if (tc_now && !auto_init)      mask_r <= 1'b1;
                else if (ch_arg && A == 4'd10) mask_r <= DB_in[2];
                else if (wr_ev && A == 4'd14)  mask_r <= 1'b0;
                else if (wr_ev && A == 4'd15)  mask_r <= DB_in[i];

                if (tc_now)                    req_r <= 1'b0;
                else if (ch_arg && A == 4'd9)  req_r <= DB_in[2];

                // A TC landing with a status read survives the read's clear.
                if (tc_now)       flag_r <= 1'b1;
                else if (stat_rd) flag_r <= 1'b0;

                tc_r <= tc_now;
            end
        end

        assign mode_flat[6*i +: 6]      = mode_r;
        assign mask[i]                  = mask_r;
        assign sw_req[i]                = req_r;
        assign tc_flag[i]               = flag_r;
        assign tc[i]                    = tc_r;
        assign cur_addr_flat[AW*i +: AW] = cur_addr;
        assign addr_ext[i]              = 16'(cur_addr);
        assign cnt_ext[i]               = 16'(cur_cnt);
    end

    // Absent channels read back as zero.
    for (genvar i = NUM_CH; i < 4; i++) begin : g_pad
        assign addr_ext[i] = '0;
        assign cnt_ext[i]  = '0;
    end

endmodule

// File: tb/tb_dma_channel_regfile.sv
module tb_dma_channel_regfile;

    logic        clk = 1'b0;
    logic        RESET_n = 1'b0;
    logic        CS_n = 1'b1, IOR_n = 1'b1, IOW_n = 1'b1;
    logic [3:0]  A = '0;
    logic [7:0]  DB_in = '0;
    logic [7:0]  DB_out;
    logic        DB_oe;
    logic [3:0]  step = '0, ext_eop = '0;
    logic [7:0]  command;
    logic [23:0] mode_flat;
    logic [3:0]  mask, sw_req, tc;
    logic [63:0] cur_addr_flat;

    int n_checks = 0;
    int n_errors = 0;

    dma_channel_regfile #(.NUM_CH(4), .AW(16), .CMD_RST(8'h00)) dut (
        .clk(clk), .RESET_n(RESET_n), .CS_n(CS_n), .IOR_n(IOR_n), .IOW_n(IOW_n),
        .A(A), .DB_in(DB_in), .DB_out(DB_out), .DB_oe(DB_oe),
        .step(step), .ext_eop(ext_eop), .command(command), .mode_flat(mode_flat),
        .mask(mask), .sw_req(sw_req), .cur_addr_flat(cur_addr_flat), .tc(tc)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0]  m_cmd, m_db;
    bit          m_ptr;
    int unsigned m_ba[4], m_ca[4], m_bc[4], m_cc[4];
    logic [5:0]  m_mode[4];
    bit          m_mask[4], m_req[4], m_flag[4], m_tc[4];
    bit          prev_rc, prev_wc;

    function automatic void model_reset();
        m_cmd = 8'h00; m_db = 8'h00; m_ptr = 0;
        for (int i = 0; i < 4; i++) begin
            m_ba[i] = 0; m_ca[i] = 0; m_bc[i] = 0; m_cc[i] = 0; m_mode[i] = '0;
            m_mask[i] = 1; m_req[i] = 0; m_flag[i] = 0; m_tc[i] = 0;
        end
    endfunction

    function automatic int unsigned set_byte(int unsigned v, bit hi, logic [7:0] d);
        if (hi) return (v & 32'h00FF) | (32'(d) << 8);
        return (v & 32'hFF00) | 32'(d);
    endfunction

    function automatic void model_tick(bit rd, bit wr, logic [3:0] a, logic [7:0] d,
                                       logic [3:0] stp, logic [3:0] eop);
        bit st[4], hit[4], auto_i[4], dec_i[4];
        int ch;
        int unsigned v;
        if (wr && a == 4'd13) begin model_reset(); return; end
        for (int i = 0; i < 4; i++) begin
            bit blk;
            blk = (wr && a < 8 && int'(a) / 2 == i) || m_cmd[2];
            st[i]     = stp[i] && !blk;
            hit[i]    = (st[i] && m_cc[i] == 0) || (eop[i] && !blk);
            auto_i[i] = m_mode[i][2];
            dec_i[i]  = m_mode[i][3];
        end
        if (rd) begin
            if (a < 8) begin
                ch = int'(a) / 2;
                v = a[0] ? m_cc[ch] : m_ca[ch];
                m_db = m_ptr ? 8'(v >> 8) : 8'(v);
            end else if (a == 8) begin
                m_db = 8'h00;
                for (int i = 0; i < 4; i++) begin m_db[i] = m_flag[i]; m_db[4+i] = m_req[i]; end
            end else m_db = 8'h00;
        end
        if (wr) begin
            if (a < 8) begin
                ch = int'(a) / 2;
                if (a[0]) begin
                    m_bc[ch] = set_byte(m_bc[ch], m_ptr, d);
                    m_cc[ch] = set_byte(m_cc[ch], m_ptr, d);
                end else begin
                    m_ba[ch] = set_byte(m_ba[ch], m_ptr, d);
                    m_ca[ch] = set_byte(m_ca[ch], m_ptr, d);
                end
            end
            case (a)
                4'd8:  m_cmd = d;
                4'd9:  m_req[d[1:0]] = d[2];
                4'd10: m_mask[d[1:0]] = d[2];
                4'd11: m_mode[d[1:0]] = d[7:2];
                4'd14: for (int i = 0; i < 4; i++) m_mask[i] = 0;
                4'd15: for (int i = 0; i < 4; i++) m_mask[i] = d[i];
                default: ;
            endcase
        end
        if (rd && a == 8) for (int i = 0; i < 4; i++) m_flag[i] = 0;
        for (int i = 0; i < 4; i++) begin
            if (st[i]) begin
                m_ca[i] = dec_i[i] ? (m_ca[i] + 32'hFFFF) & 32'hFFFF : (m_ca[i] + 1) & 32'hFFFF;
                m_cc[i] = (m_cc[i] + 32'hFFFF) & 32'hFFFF;
            end
            m_tc[i] = hit[i];
            if (hit[i]) begin
                m_flag[i] = 1; m_req[i] = 0;
                if (auto_i[i]) begin m_ca[i] = m_ba[i]; m_cc[i] = m_bc[i]; end
                else m_mask[i] = 1;
            end
        end
        if (wr && a == 4'd12) m_ptr = 0;
        else if ((rd || wr) && a < 8) m_ptr = !m_ptr;
    endfunction

    function automatic logic [3:0] pack4(input bit b[4]);
        for (int i = 0; i < 4; i++) pack4[i] = b[i];
    endfunction

    function automatic logic [63:0] exp_addr();
        for (int i = 0; i < 4; i++) exp_addr[16*i +: 16] = 16'(m_ca[i]);
    endfunction

    function automatic logic [23:0] exp_mode();
        for (int i = 0; i < 4; i++) exp_mode[6*i +: 6] = m_mode[i];
    endfunction

    // ---------------- bus drivers ----------------
    task automatic cycle(input bit cs, input bit rd_l, input bit wr_l, input logic [3:0] a,
                         input logic [7:0] d, input logic [3:0] stp, input logic [3:0] eop);
        bit rc, wc;
        CS_n = !cs; IOR_n = !rd_l; IOW_n = !wr_l; A = a; DB_in = d;
        step = stp; ext_eop = eop;
        rc = cs && rd_l && !wr_l;
        wc = cs && wr_l && !rd_l;
        model_tick(rc && !prev_rc, wc && !prev_wc, a, d, stp, eop);
        prev_rc = rc; prev_wc = wc;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 4'd0, 8'h00, 4'b0, 4'b0);
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
        cycle(1, 0, 1, a, d, 4'b0, 4'b0);
        idle();
    endtask

    task automatic bus_rd(input logic [3:0] a);
        cycle(1, 1, 0, a, 8'h00, 4'b0, 4'b0);
        idle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus_wr(4'd8, 8'hA5);
        n_checks++;
        if (command !== 8'hA5) begin n_errors++; $display("FAIL cmd_write: got %h want a5", command); end
        bus_wr(4'd14, 8'h00);
        n_checks++;
        if (mask !== 4'h0) begin n_errors++; $display("FAIL clear_masks: got %h want 0", mask); end
        cycle(1, 0, 1, 4'd8, 8'h3C, 4'b0, 4'b0);
        cycle(1, 0, 1, 4'd8, 8'h3C, 4'b0, 4'b0);
        #2 RESET_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (command !== 8'h00 || mask !== 4'hF || DB_out !== 8'h00 || tc !== 4'h0 ||
            sw_req !== 4'h0 || mode_flat !== 24'h0 || cur_addr_flat !== 64'h0) begin
            n_errors++;
            $display("FAIL reset_state: cmd=%h mask=%h db=%h tc=%h req=%h mode=%h addr=%h want 00 f 00 0 0 0 0",
                     command, mask, DB_out, tc, sw_req, mode_flat, cur_addr_flat);
        end
        IOW_n = 1'b1; IOR_n = 1'b0; #1;
        n_checks++;
        if (DB_oe !== 1'b1) begin n_errors++; $display("FAIL db_oe_read: got %b want 1", DB_oe); end
        IOW_n = 1'b0; #1;
        n_checks++;
        if (DB_oe !== 1'b0) begin n_errors++; $display("FAIL db_oe_both: got %b want 0", DB_oe); end
        CS_n = 1'b1; IOR_n = 1'b1; IOW_n = 1'b1;
        prev_rc = 0; prev_wc = 0;
        @(posedge clk); #1;
        RESET_n = 1'b1;
        @(posedge clk); #1;
        cycle(1, 1, 1, 4'd8, 8'hFF, 4'b0, 4'b0);
        idle();
        n_checks++;
        if (command !== 8'h00) begin n_errors++; $display("FAIL both_strobes: cmd=%h want 00", command); end
    endtask

    task automatic test_byte_ptr();
        bus_wr(4'd12, 8'h00);
        bus_wr(4'd2, 8'h34);
        bus_wr(4'd2, 8'h12);
        n_checks++;
        if (cur_addr_flat[31:16] !== 16'h1234) begin
            n_errors++; $display("FAIL ptr_write: addr1=%h want 1234", cur_addr_flat[31:16]);
        end
        bus_rd(4'd2);
        n_checks++;
        if (DB_out !== 8'h34) begin n_errors++; $display("FAIL ptr_read_lo: got %h want 34", DB_out); end
        bus_rd(4'd2);
        n_checks++;
        if (DB_out !== 8'h12) begin n_errors++; $display("FAIL ptr_read_hi: got %h want 12", DB_out); end
        repeat (5) cycle(1, 1, 0, 4'd2, 8'h00, 4'b0, 4'b0);
        idle();
        n_checks++;
        if (DB_out !== 8'h34) begin n_errors++; $display("FAIL held_read: got %h want 34", DB_out); end
        bus_rd(4'd2);
        n_checks++;
        if (DB_out !== 8'h12) begin n_errors++; $display("FAIL held_single_toggle: got %h want 12", DB_out); end
    endtask

    task automatic test_tc_count();
        logic [3:0] want;
        bus_wr(4'd12, 8'h00);
        bus_wr(4'd1, 8'h02);
        bus_wr(4'd1, 8'h00);
        bus_wr(4'd11, 8'h48);
        bus_wr(4'd14, 8'h00);
        bus_wr(4'd9, 8'h04);
        n_checks++;
        if (sw_req !== 4'b0001) begin n_errors++; $display("FAIL sw_req_set: got %h want 1", sw_req); end
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 0, 4'd0, 8'h00, 4'b0001, 4'b0);
            want = (k == 2) ? 4'b0001 : 4'b0000;
            n_checks++;
            if (tc !== want) begin n_errors++; $display("FAIL tc_step%0d: got %h want %h", k, tc, want); end
        end
        idle();
        n_checks++;
        if (tc !== 4'b0 || mask[0] !== 1'b1 || sw_req[0] !== 1'b0 || cur_addr_flat[15:0] !== 16'h0003) begin
            n_errors++;
            $display("FAIL tc_effects: tc=%h mask0=%b req0=%b addr0=%h want 0 1 0 0003",
                     tc, mask[0], sw_req[0], cur_addr_flat[15:0]);
        end
        bus_rd(4'd8);
        n_checks++;
        if (DB_out !== 8'h01) begin n_errors++; $display("FAIL status1: got %h want 01", DB_out); end
        bus_rd(4'd8);
        n_checks++;
        if (DB_out !== 8'h00) begin n_errors++; $display("FAIL status2: got %h want 00", DB_out); end
        bus_wr(4'd12, 8'h00);
        bus_rd(4'd1);
        bus_rd(4'd1);
        n_checks++;
        if (DB_out !== 8'hFF) begin n_errors++; $display("FAIL count_wrap: got %h want ff", DB_out); end
    endtask

    task automatic test_autoinit();
        bus_wr(4'd12, 8'h00);
        bus_wr(4'd4, 8'h00);
        bus_wr(4'd4, 8'h80);
        bus_wr(4'd5, 8'h01);
        bus_wr(4'd5, 8'h00);
        bus_wr(4'd11, 8'h5A);
        bus_wr(4'd10, 8'h02);
        cycle(0, 0, 0, 4'd0, 8'h00, 4'b0100, 4'b0);
        n_checks++;
        if (cur_addr_flat[47:32] !== 16'h8001 || tc !== 4'b0) begin
            n_errors++; $display("FAIL auto_step1: addr=%h tc=%h want 8001 0", cur_addr_flat[47:32], tc);
        end
        cycle(0, 0, 0, 4'd0, 8'h00, 4'b0100, 4'b0);
        n_checks++;
        if (cur_addr_flat[47:32] !== 16'h8000 || tc !== 4'b0100 || mask[2] !== 1'b0) begin
            n_errors++;
            $display("FAIL auto_reload: addr=%h tc=%h mask2=%b want 8000 4 0", cur_addr_flat[47:32], tc, mask[2]);
        end
        cycle(0, 0, 0, 4'd0, 8'h00, 4'b0100, 4'b0);
        n_checks++;
        if (cur_addr_flat[47:32] !== 16'h8001 || tc !== 4'b0) begin
            n_errors++; $display("FAIL auto_after: addr=%h tc=%h want 8001 0", cur_addr_flat[47:32], tc);
        end
    endtask

    task automatic test_decrement_disable();
        bus_wr(4'd12, 8'h00);
        bus_wr(4'd6, 8'h00);
        bus_wr(4'd6, 8'h00);
        bus_wr(4'd11, 8'h2B);
        cycle(0, 0, 0, 4'd0, 8'h00, 4'b1000, 4'b0);
        n_checks++;
        if (cur_addr_flat[63:48] !== 16'hFFFF || tc !== 4'b1000) begin
            n_errors++; $display("FAIL decrement: addr=%h tc=%h want ffff 8", cur_addr_flat[63:48], tc);
        end
        bus_wr(4'd8, 8'h04);
        cycle(0, 0, 0, 4'd0, 8'h00, 4'b1001, 4'b1000);
        n_checks++;
        if (cur_addr_flat[63:48] !== 16'hFFFF || cur_addr_flat[15:0] !== 16'h0003 || tc !== 4'b0) begin
            n_errors++;
            $display("FAIL disabled: addr3=%h addr0=%h tc=%h want ffff 0003 0",
                     cur_addr_flat[63:48], cur_addr_flat[15:0], tc);
        end
        bus_wr(4'd8, 8'h00);
    endtask

    task automatic test_collisions();
        bus_wr(4'd12, 8'h00);
        cycle(1, 0, 1, 4'd3, 8'h77, 4'b0010, 4'b0);
        idle();
        n_checks++;
        if (cur_addr_flat[31:16] !== 16'h1234 || tc !== 4'b0) begin
            n_errors++; $display("FAIL step_dropped: addr1=%h tc=%h want 1234 0", cur_addr_flat[31:16], tc);
        end
        bus_wr(4'd12, 8'h00);
        bus_rd(4'd3);
        n_checks++;
        if (DB_out !== 8'h77) begin n_errors++; $display("FAIL write_wins: got %h want 77", DB_out); end
        bus_rd(4'd3);
        n_checks++;
        if (DB_out !== 8'h00) begin n_errors++; $display("FAIL write_wins_hi: got %h want 00", DB_out); end
        bus_rd(4'd8);
        n_checks++;
        if (DB_out !== 8'h0C) begin n_errors++; $display("FAIL status_flags: got %h want 0c", DB_out); end
        cycle(1, 1, 0, 4'd8, 8'h00, 4'b0, 4'b1000);
        n_checks++;
        if (DB_out !== 8'h00 || tc !== 4'b1000) begin
            n_errors++; $display("FAIL status_tc_same: db=%h tc=%h want 00 8", DB_out, tc);
        end
        idle();
        bus_rd(4'd8);
        n_checks++;
        if (DB_out !== 8'h08) begin n_errors++; $display("FAIL flag_kept: got %h want 08", DB_out); end
        bus_wr(4'd10, 8'h03);
        n_checks++;
        if (mask[3] !== 1'b0) begin n_errors++; $display("FAIL mask_clear: got %b want 0", mask[3]); end
        cycle(1, 0, 1, 4'd10, 8'h03, 4'b0, 4'b1000);
        idle();
        n_checks++;
        if (mask[3] !== 1'b1) begin n_errors++; $display("FAIL tc_mask_wins: got %b want 1", mask[3]); end
    endtask

    task automatic test_random();
        int op, nph;
        logic [3:0] a, stp, eop;
        logic [7:0] d;
        bit act, both;
        for (int it = 0; it < 400; it++) begin
            op  = $urandom_range(0, 9);
            a   = 4'($urandom_range(0, 15));
            d   = 8'($urandom);
            nph = $urandom_range(1, 3);
            if (a == 4'd13) a = 4'd12;
            if (op <= 3 && a < 8 && a[0]) d = 8'($urandom_range(0, 3));
            if (op <= 3 && a == 4'd8) d[2] = ($urandom_range(0, 3) == 0);
            for (int ph = 0; ph <= nph; ph++) begin
                act  = (ph < nph) && (op <= 6);
                both = (op == 7) && (ph == 0);
                stp  = ($urandom_range(0, 2) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
                eop  = ($urandom_range(0, 15) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
                cycle(act || both, (act && op >= 4) || both, (act && op <= 3) || both, a, d, stp, eop);
                n_checks++;
                if (command !== m_cmd || mask !== pack4(m_mask) || sw_req !== pack4(m_req) ||
                    tc !== pack4(m_tc) || DB_out !== m_db || cur_addr_flat !== exp_addr() ||
                    mode_flat !== exp_mode()) begin
                    n_errors++;
                    $display("FAIL random it=%0d ph=%0d: cmd=%h/%h mask=%h/%h req=%h/%h tc=%h/%h db=%h/%h addr=%h/%h mode=%h/%h (got/want)",
                             it, ph, command, m_cmd, mask, pack4(m_mask), sw_req, pack4(m_req),
                             tc, pack4(m_tc), DB_out, m_db, cur_addr_flat, exp_addr(), mode_flat, exp_mode());
                end
            end
        end
    endtask

    task automatic test_master_clear();
        bus_wr(4'd8, 8'h5A);
        bus_wr(4'd11, 8'hFD);
        bus_wr(4'd12, 8'h00);
        bus_wr(4'd0, 8'h99);
        bus_rd(4'd0);
        cycle(1, 0, 1, 4'd13, 8'h00, 4'b1111, 4'b1111);
        idle();
        n_checks++;
        if (command !== 8'h00 || mask !== 4'hF || DB_out !== 8'h00 || tc !== 4'h0 ||
            sw_req !== 4'h0 || mode_flat !== 24'h0 || cur_addr_flat !== 64'h0) begin
            n_errors++;
            $display("FAIL master_clear: cmd=%h mask=%h db=%h tc=%h req=%h mode=%h addr=%h want 00 f 00 0 0 0 0",
                     command, mask, DB_out, tc, sw_req, mode_flat, cur_addr_flat);
        end
        bus_rd(4'd8);
        n_checks++;
        if (DB_out !== 8'h00) begin n_errors++; $display("FAIL mclr_status: got %h want 00", DB_out); end
        bus_wr(4'd0, 8'hAB);
        n_checks++;
        if (cur_addr_flat[15:0] !== 16'h00AB) begin
            n_errors++; $display("FAIL mclr_ptr: addr0=%h want 00ab", cur_addr_flat[15:0]);
        end
    endtask

    initial begin
        model_reset();
        prev_rc = 0; prev_wc = 0;
        repeat (3) @(posedge clk);
        #1 RESET_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_byte_ptr();
        test_tc_count();
        test_autoinit();
        test_decrement_disable();
        test_collisions();
        test_random();
        test_master_clear();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
